// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and counting-mode enum.
package gray_pkg;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Works for any narrower width as long as the value is zero-extended.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_code_encoder.sv
// gray_code_encoder: combinational binary-to-Gray mapping.
module gray_code_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down counter with load, wrap or saturate, and
// registered binary and Gray outputs.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] binary_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             tc_o,
    output logic             limit_o
);
    localparam mode_e MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

    logic [WIDTH-1:0] binary_q, binary_d, gray_q, gray_d, step;
    logic             limit_q, limit_d, at_limit;

    always_comb begin
        at_limit = up_i ? &binary_q : ~|binary_q;
        step     = up_i ? binary_q + WIDTH'(1) : binary_q - WIDTH'(1);
        binary_d = load_i ? load_value_i :
                   (!ce_i || (at_limit && MODE == MODE_SAT)) ? binary_q : step;
        limit_d  = !load_i && ce_i && at_limit;
    end

    // Gray register is fed from the next binary value so gray_o is never a decode of flop outputs.
    gray_code_encoder #(.WIDTH(WIDTH)) u_enc (
        .bin_i (binary_d),
        .gray_o(gray_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            binary_q <= RESET_VALUE;
            gray_q   <= RESET_GRAY;
            limit_q  <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            limit_q  <= limit_d;
        end
    end

    assign binary_o = binary_q;
    assign gray_o   = gray_q;
    assign limit_o  = limit_q;
    assign tc_o     = at_limit;
endmodule
